// File: rtl/sha3_digest_serializer_if.sv
// sha3_digest_serializer_if
//   Bundles the state-capture and digest-stream signals of the SHA3 digest
//   serializer.
//   Capture side: USER (mode), D_in (Keccak state, D_in[x][y] = A[x][y]),
//                 state_valid / state_ready.
//   Stream side:  out_data / out_valid / out_ready / out_last, plus the
//                 mode_err pulse.
//   slave  = serializer view, master = producer/consumer view.
interface sha3_digest_serializer_if;
  logic [2:0]             USER;
  logic [4:0][4:0][63:0]  D_in;
  logic                   state_valid;
  logic                   state_ready;
  logic [15:0]            out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic                   mode_err;

  modport slave (
    input  USER, D_in, state_valid, out_ready,
    output state_ready, out_data, out_valid, out_last, mode_err
  );

  modport master (
    output USER, D_in, state_valid, out_ready,
    input  state_ready, out_data, out_valid, out_last, mode_err
  );
endinterface

// File: rtl/sha3_digest_serializer.sv
// sha3_digest_serializer
//   Captures the final 1600-bit Keccak state, truncates it to the digest
//   length selected by USER and streams it as 16-bit little-endian words.
//   Ports:
//     ACLK     clock, rising edge
//     ARESETn  synchronous active-low reset
//     bus      sha3_digest_serializer_if.slave (capture + stream handshake)
//   Word k comes from lane k/4, bits [16*(k%4)+15 : 16*(k%4)].
module sha3_digest_serializer #(
  parameter int OUT_W  = 16,
  parameter int LANE_W = 64
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  sha3_digest_serializer_if.slave   bus
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                      state_q, state_d;
  logic [6:0]                  k_q, k_d;
  logic [6:0]                  n_q, n_d;
  logic [24:0][LANE_W-1:0]     lanes_q, lanes_d;
  logic [OUT_W-1:0]            out_data_q, out_data_d;
  logic                        out_valid_q, out_valid_d;
  logic                        out_last_q, out_last_d;
  logic                        mode_err_q, mode_err_d;

  // Word following the current one, read from the captured lanes.
  logic [6:0]                  k_inc;
  logic [4:0]                  lsel;
  logic [LANE_W-1:0]           lane_w;
  logic [OUT_W-1:0]            word_nxt;

  always_comb begin
    k_inc  = k_q + 7'd1;
    lsel   = k_inc[6:2];
    lane_w = '0;
    if (lsel < 5'd25) lane_w = lanes_q[lsel];
    word_nxt = lane_w[k_inc[1:0]*OUT_W +: OUT_W];
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    n_d         = n_q;
    lanes_d     = lanes_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    mode_err_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.state_valid) begin
          // Lane index i = x + 5*y.
          for (int i = 0; i < 25; i++) lanes_d[i] = bus.D_in[i % 5][i / 5];
          unique case (bus.USER)
            3'd0:    n_d = 7'd14;
            3'd1:    n_d = 7'd16;
            3'd2:    n_d = 7'd24;
            3'd3:    n_d = 7'd32;
            3'd4:    n_d = 7'd84;
            3'd5:    n_d = 7'd68;
            default: n_d = n_q;
          endcase
          if (bus.USER[2:1] == 2'b11) begin
            mode_err_d = 1'b1;
          end else begin
            state_d     = SEND;
            k_d         = '0;
            out_valid_d = 1'b1;
            // Lanes are not registered yet, so word 0 comes straight from D_in.
            out_data_d  = bus.D_in[0][0][OUT_W-1:0];
            out_last_d  = 1'b0;
          end
        end
      end
      SEND: begin
        if (out_valid_q && bus.out_ready) begin
          if (k_q == n_q - 7'd1) begin
            state_d     = IDLE;
            k_d         = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
          end else begin
            k_d        = k_inc;
            out_data_d = word_nxt;
            out_last_d = (k_inc == n_q - 7'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      k_q         <= '0;
      n_q         <= '0;
      lanes_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      mode_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      lanes_q     <= lanes_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      mode_err_q  <= mode_err_d;
    end
  end

  assign bus.state_ready = (state_q == IDLE);
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_last    = out_last_q;
  assign bus.mode_err    = mode_err_q;

endmodule

// File: tb/tb_sha3_digest_serializer.sv
// tb_sha3_digest_serializer
//   Scoreboard bench: expected {last,word} pairs are queued when a state is
//   captured and popped by a negedge monitor on every transfer.
module tb_sha3_digest_serializer;

  logic ACLK;
  logic ARESETn;
  sha3_digest_serializer_if dif ();

  sha3_digest_serializer #(.OUT_W(16), .LANE_W(64)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (dif)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  logic [16:0] sbq[$];
  int          xfer_cnt = 0;
  int          vcyc     = 0;
  logic [15:0] last_word = '0;
  bit          held = 0;
  logic [15:0] held_data;
  logic        held_last;

  // Monitor: stability while stalled, scoreboard compare on transfer.
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      held = 0;
    end else begin
      if (held && dif.out_valid) begin
        chk("hold_data", {16'h0, dif.out_data}, {16'h0, held_data});
        chk("hold_last", {31'h0, dif.out_last}, {31'h0, held_last});
      end
      if (dif.out_valid) vcyc++;
      if (dif.out_valid && dif.out_ready) begin
        xfer_cnt++;
        chk("sb_nonempty", {31'h0, sbq.size() != 0}, 32'd1);
        if (sbq.size() != 0) begin
          logic [16:0] e;
          e = sbq.pop_front();
          chk("word", {15'h0, dif.out_last, dif.out_data}, {15'h0, e});
        end
        if (dif.out_last) last_word = dif.out_data;
      end
      held      = dif.out_valid && !dif.out_ready;
      held_data = dif.out_data;
      held_last = dif.out_last;
    end
  end

  task automatic fill();
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        for (int j = 0; j < 4; j++)
          dif.D_in[x][y][16*j +: 16] = {8'(x + 5*y), 8'(j)};
  endtask

  function automatic int nwords(input logic [2:0] m);
    case (m)
      3'd0: return 14;
      3'd1: return 16;
      3'd2: return 24;
      3'd3: return 32;
      3'd4: return 84;
      3'd5: return 68;
      default: return 0;
    endcase
  endfunction

  // Called at a negedge; leaves at the negedge after the capture edge.
  task automatic capture(input logic [2:0] mode);
    int t = 0;
    int n;
    while (!dif.state_ready && t < 300) begin @(negedge ACLK); t++; end
    chk("ready_wait", {31'h0, dif.state_ready}, 32'd1);
    fill();
    n = nwords(mode);
    for (int k = 0; k < n; k++)
      sbq.push_back({(k == n - 1), 8'(k / 4), 8'(k % 4)});
    dif.USER        = mode;
    dif.state_valid = 1'b1;
    @(posedge ACLK);
    #1;
    dif.state_valid = 1'b0;
    dif.USER        = 3'd2;     // later USER / D_in changes must not matter
    dif.D_in        = '1;
    @(negedge ACLK);
    chk("lat_valid", {31'h0, dif.out_valid}, {31'h0, n != 0});
    chk("mode_err",  {31'h0, dif.mode_err},  {31'h0, n == 0});
  endtask

  task automatic wait_done();
    int t = 0;
    while (dif.out_valid && t < 500) begin @(negedge ACLK); t++; end
    chk("done_timeout", {31'h0, t < 500}, 32'd1);
    chk("ready_after",  {31'h0, dif.state_ready}, 32'd1);
    chk("sb_empty",     sbq.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    ARESETn         = 1'b0;
    dif.state_valid = 1'b1;
    dif.USER        = 3'd1;
    dif.out_ready   = 1'b0;
    fill();

    // Reset with state_valid held high
    @(posedge ACLK);
    repeat (2) begin
      @(negedge ACLK);
      chk("rst_valid", {31'h0, dif.out_valid}, 32'd0);
      chk("rst_last",  {31'h0, dif.out_last},  32'd0);
      chk("rst_data",  {16'h0, dif.out_data},  32'd0);
      chk("rst_err",   {31'h0, dif.mode_err},  32'd0);
    end
    @(posedge ACLK);
    #1;
    ARESETn         = 1'b1;
    dif.state_valid = 1'b0;
    @(negedge ACLK);
    chk("rst_ready", {31'h0, dif.state_ready}, 32'd1);
    chk("rst_nocap", {31'h0, dif.out_valid},   32'd0);

    // SHA3-256 ordering
    dif.out_ready = 1'b1;
    xfer_cnt = 0;
    capture(3'd1);
    wait_done();
    chk("256_count", xfer_cnt, 32'd16);
    chk("256_last",  {16'h0, last_word}, 32'h0303);

    // SHA3-224 truncation
    xfer_cnt = 0;
    capture(3'd0);
    wait_done();
    chk("224_count", xfer_cnt, 32'd14);
    chk("224_last",  {16'h0, last_word}, 32'h0301);

    // SHA3-512 with alternating backpressure
    xfer_cnt = 0;
    vcyc     = 0;
    dif.out_ready = 1'b1;
    capture(3'd3);
    begin
      int t = 0;
      while (dif.out_valid && t < 300) begin
        @(posedge ACLK);
        #1;
        dif.out_ready = ~dif.out_ready;
        @(negedge ACLK);
        t++;
      end
    end
    dif.out_ready = 1'b1;
    chk("bp_cycles", vcyc, 32'd63);
    chk("bp_count",  xfer_cnt, 32'd32);
    chk("bp_last",   {16'h0, last_word}, 32'h0703);
    chk("bp_sb",     sbq.size(), 32'd0);

    // SHAKE modes, with a state_valid pulse while busy
    for (int m = 4; m <= 5; m++) begin
      xfer_cnt = 0;
      capture(3'(m));
      repeat (10) @(negedge ACLK);
      dif.USER        = 3'd0;
      dif.state_valid = 1'b1;
      chk("busy_ready", {31'h0, dif.state_ready}, 32'd0);
      @(posedge ACLK);
      #1;
      dif.state_valid = 1'b0;
      @(negedge ACLK);
      wait_done();
      chk("shake_count", xfer_cnt, (m == 4) ? 32'd84 : 32'd68);
      chk("shake_last",  {16'h0, last_word}, (m == 4) ? 32'h1403 : 32'h1003);
    end

    // Reserved mode
    xfer_cnt = 0;
    capture(3'd7);
    @(negedge ACLK);
    chk("err_pulse",  {31'h0, dif.mode_err},    32'd0);
    chk("err_idle",   {31'h0, dif.state_ready}, 32'd1);
    chk("err_novalid",{31'h0, dif.out_valid},   32'd0);
    chk("err_count",  xfer_cnt, 32'd0);

    // Mid-stream reset after the 5th transfer
    xfer_cnt = 0;
    capture(3'd1);
    begin
      int t = 0;
      while (xfer_cnt < 5 && t < 100) begin @(posedge ACLK); t++; end
      chk("mrst_wait", {31'h0, t < 100}, 32'd1);
    end
    #1;
    ARESETn       = 1'b0;
    dif.out_ready = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    chk("mrst_valid", {31'h0, dif.out_valid}, 32'd0);
    chk("mrst_count", xfer_cnt, 32'd5);
    sbq.delete();
    @(posedge ACLK);
    #1;
    ARESETn       = 1'b1;
    dif.out_ready = 1'b1;
    @(negedge ACLK);
    xfer_cnt = 0;
    capture(3'd1);
    wait_done();
    chk("restart_count", xfer_cnt, 32'd16);
    chk("restart_last",  {16'h0, last_word}, 32'h0303);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sha3_digest_serializer.md
Name: sha3_digest_serializer

Overview:
- Output-side counterpart to the 16-bit input path of the SHA3 top.
- Accepts the final 1600-bit Keccak state after the permutation completes.
- Truncates the state to the digest length selected by USER.
- Streams the digest out as 16-bit words over a valid/ready handshake, marking the final word with out_last.

Parameters:
- OUT_W, 16, output word width in bits; fixed at 16, no other value supported.
- LANE_W, 64, Keccak lane width in bits; fixed at 64.

Ports:
- ACLK  input  1  clock; all logic rising-edge.
- ARESETn  input  1  reset, synchronous, active-low.
- USER  input  3  mode select, sampled only on state capture:
  - 0 SHA3-224, 1 SHA3-256, 2 SHA3-384, 3 SHA3-512
  - 4 SHAKE128 (one rate block), 5 SHAKE256 (one rate block)
  - 6 and 7 reserved
- D_in  input  [4:0][4:0][63:0]  Keccak state; D_in[x][y] is lane A[x][y], lane index i = x + 5*y.
- state_valid  input  1  D_in and USER are valid.
- state_ready  output  1  block can capture a state.
- out_data  output  16  digest word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- out_last  output  1  current word is the final digest word.
- mode_err  output  1  one-cycle pulse when a reserved USER value is captured.

Behaviour:
- Reset (ARESETn=0 at a rising edge):
  - FSM goes to IDLE; word index = 0.
  - Captured state register cleared to 0.
  - out_data=0, out_valid=0, out_last=0, mode_err=0.
  - state_ready=1 from the first cycle after reset.
  - Reset mid-stream abandons the current digest; no further words are emitted.
- FSM states: IDLE, SEND.
- IDLE:
  - state_ready=1 (combinational from state), out_valid=0.
  - On state_valid & state_ready: register D_in and latch word limit N from USER.
  - N values: 224→14, 256→16, 384→24, 512→32, SHAKE128→84, SHAKE256→68.
  - Valid mode: go to SEND.
  - Reserved mode: stay in IDLE, assert mode_err for exactly one cycle (the cycle after capture), emit nothing.
- SEND:
  - state_ready=0; out_valid=1 starting the cycle after capture (latency 1).
  - out_data = word[k], where lane = k/4, slice = k%4, and word[k] = lane bits [16*slice+15 : 16*slice]. This is byte-little-endian, so out_data[7:0] is the earlier digest byte.
  - out_last = (k == N-1).
- Handshake: a transfer occurs on out_valid & out_ready.
  - While out_valid=1 and out_ready=0: out_data, out_last and k are held stable.
  - On transfer with k < N-1: k increments.
  - On transfer with k == N-1: next cycle out_valid=0, out_last=0, k=0, FSM returns to IDLE.
- Back-to-back states: state_valid during SEND is ignored (state_ready=0). The next state is captured no earlier than the first IDLE cycle after the last transfer.
- USER changes during SEND have no effect.
- D_in changes after capture have no effect.
- Outputs out_data, out_valid, out_last and mode_err are registered.
- SHA3-224 ends mid-lane: the last word is lane 3, slice 1; lane 3 bits [63:32] are never emitted.

Test Plan:
- Reset check:
  - Stimulus: hold ARESETn=0 for 2 cycles with state_valid=1.
  - Required: out_valid=0, out_last=0, out_data=0, mode_err=0 throughout reset. state_ready=1 on the first cycle after release. No capture occurs while in reset.
- SHA3-256 word ordering:
  - Stimulus: USER=1; each 16-bit slice j of lane i is loaded with {8'(i),8'(j)}; out_ready=1.
  - Required: 16 words 0x0000,0x0001,0x0002,0x0003,0x0100,…,0x0303. First word appears 1 cycle after capture. out_last=1 only on 0x0303. state_ready=1 the cycle after.
- SHA3-224 truncation:
  - Stimulus: same pattern, USER=0.
  - Required: exactly 14 words; last word is 0x0301 with out_last=1; 0x0302 is never seen.
- Backpressure:
  - Stimulus: USER=3; out_ready toggles 1,0,1,0,….
  - Required: 32 distinct words 0x0000…0x0703, each transferred exactly once. out_data stable during every out_ready=0 cycle. Total SEND duration is 63 cycles.
- SHAKE modes:
  - USER=4: 84 words, last word 0x1403 (lane 20 = A[0][4]).
  - USER=5: 68 words, last word 0x1003.
  - In both, state_valid pulsed during SEND is ignored.
- Error and mid-stream reset:
  - USER=7 capture: mode_err high for 1 cycle, out_valid stays 0, FSM remains in IDLE.
  - USER=1, reset asserted after the 5th transfer: out_valid=0 the next cycle. A new capture restarts output at word 0x0000.
